// File: rtl/codes_pkg.sv
// Shared CPU constants plus fetch-stage types: FSM states, fetch queue entry, PC increment.
package codes_pkg;
  localparam int unsigned WORD_WIDTH = 32;
  localparam int unsigned DEPTH      = 256;

  typedef enum logic [1:0] {
    S_BOOT,
    S_RUN,
    S_HALT,
    S_FAULT
  } fetch_state_e;

  typedef struct packed {
    logic [WORD_WIDTH-1:0] pc;
    logic [WORD_WIDTH-1:0] instr;
  } fq_entry_t;

  // Sequential PC wraps modulo DEPTH words at the top of instruction memory.
  function automatic logic [WORD_WIDTH-1:0] next_pc(input logic [WORD_WIDTH-1:0] pc);
    if (pc == WORD_WIDTH'((DEPTH - 1) * 4)) return '0;
    return pc + WORD_WIDTH'(4);
  endfunction
endpackage

// File: rtl/fetch_ctrl_if.sv
// Fetch-stage bus: instruction memory address/data and the valid/ready path to decode.
interface fetch_ctrl_if;
  import codes_pkg::*;

  logic [WORD_WIDTH-1:0] imem_addr;
  logic [WORD_WIDTH-1:0] imem_instr;
  logic                  if_valid;
  logic                  if_ready;
  logic [WORD_WIDTH-1:0] if_instr;
  logic [WORD_WIDTH-1:0] if_pc;

  modport master (
    output imem_addr, if_valid, if_instr, if_pc,
    input  imem_instr, if_ready
  );

  modport slave (
    input  imem_addr, if_valid, if_instr, if_pc,
    output imem_instr, if_ready
  );
endinterface

// File: rtl/fetch_queue.sv
// Circular FIFO of {pc, instr} entries between fetch and decode; flush empties it at once.
module fetch_queue
  import codes_pkg::*;
#(
  parameter int unsigned FQ_DEPTH = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      push,
  input  fq_entry_t                 push_data,
  input  logic                      pop,
  input  logic                      flush,
  output fq_entry_t                 head,
  output logic [$clog2(FQ_DEPTH):0] count,
  output logic                      empty
);
  localparam int unsigned AW = $clog2(FQ_DEPTH);
  localparam int unsigned CW = AW + 1;

  fq_entry_t     mem [FQ_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          full;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(FQ_DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  // Storage needs no reset: entries are only visible through count.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end
endmodule

// File: rtl/fetch_ctrl.sv
// Fetch controller: owns the PC, sequences imem, queues {pc, instr} for decode, handles
// redirect and halt. Optional MISALIGN_TRAP_EN: misaligned redirect traps into S_FAULT.
module fetch_ctrl
  import codes_pkg::*;
#(
  parameter logic [WORD_WIDTH-1:0] RESET_PC = '0,
  parameter int unsigned           FQ_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  fetch_ctrl_if.master          bus,
  input  logic                  redirect_valid,
  input  logic [WORD_WIDTH-1:0] redirect_pc,
  input  logic                  halt_req,
  output logic                  halted
`ifdef MISALIGN_TRAP_EN
  ,
  output logic                  fetch_fault
`endif
);
  localparam int unsigned CW = $clog2(FQ_DEPTH) + 1;

  fetch_state_e          state;
  fetch_state_e          state_nxt;
  logic [WORD_WIDTH-1:0] pc;
  logic                  redirect_take;
  logic                  load_pc;
  logic                  pop;
  logic                  fetch;
  fq_entry_t             fq_head;
  fq_entry_t             fq_push_data;
  logic [CW-1:0]         fq_count;
  logic                  fq_empty;

`ifdef MISALIGN_TRAP_EN
  logic misalign;
  assign misalign = (redirect_pc[1:0] != 2'b00);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_BOOT;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_BOOT: state_nxt = S_RUN;
      S_RUN, S_HALT: begin
        if (redirect_valid) begin
`ifdef MISALIGN_TRAP_EN
          if (misalign) state_nxt = S_FAULT;
          else          state_nxt = halt_req ? S_HALT : S_RUN;
`else
          state_nxt = halt_req ? S_HALT : S_RUN;
`endif
        end else if (halt_req) begin
          state_nxt = S_HALT;
        end
      end
      default: state_nxt = state;
    endcase
  end

  // Redirect outranks everything: it cancels this cycle's push and pop as well.
  always_comb begin
    redirect_take = 1'b0;
    case (state)
      S_RUN, S_HALT: redirect_take = redirect_valid;
      default:       redirect_take = 1'b0;
    endcase
`ifdef MISALIGN_TRAP_EN
    load_pc = redirect_take && !misalign;
`else
    load_pc = redirect_take;
`endif
    pop    = bus.if_valid && bus.if_ready && !redirect_take;
    fetch  = (state == S_RUN) && !halt_req && !redirect_take &&
             ((fq_count < CW'(FQ_DEPTH)) || pop);
    halted = (state == S_HALT) || (state == S_FAULT);
  end

`ifdef MISALIGN_TRAP_EN
  assign fetch_fault = (state == S_FAULT);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       pc <= RESET_PC;
    else if (load_pc) pc <= redirect_pc & ~WORD_WIDTH'(3);
    else if (fetch)   pc <= next_pc(pc);
  end

  assign fq_push_data = '{pc: pc, instr: bus.imem_instr};

  fetch_queue #(
    .FQ_DEPTH (FQ_DEPTH)
  ) u_queue (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fetch),
    .push_data (fq_push_data),
    .pop       (pop),
    .flush     (redirect_take),
    .head      (fq_head),
    .count     (fq_count),
    .empty     (fq_empty)
  );

  assign bus.imem_addr = pc;
  assign bus.if_valid  = !fq_empty;
  assign bus.if_instr  = fq_empty ? '0 : fq_head.instr;
  assign bus.if_pc     = fq_empty ? '0 : fq_head.pc;
endmodule
